// File: rtl/wb_arbiter_if.sv
// Write-back bus bundle between the ALU/memory producers and the register-file write arbiter.
// "master" is the producer/pipeline side, "slave" is the arbiter.
interface wb_arbiter_if #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              alu_valid;
    logic [AW-1:0]     alu_reg;
    logic [DW-1:0]     alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [AW-1:0]     mem_reg;
    logic [DW-1:0]     mem_data;
    logic              regwrite;
    logic [AW-1:0]     wrreg;
    logic [DW-1:0]     wrdata;
    logic [2**AW-1:0]  busy_mask;
    logic [CW-1:0]     fifo_count;

    modport master (
        output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
        input  mem_ready, regwrite, wrreg, wrdata, busy_mask, fifo_count
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
        output mem_ready, regwrite, wrreg, wrdata, busy_mask, fifo_count
    );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: the ALU result has strict priority on the register-file write port, memory
// results wait in a small FIFO whose entries are killed when a younger ALU write hits the same register.
module wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    wb_arbiter_if.slave   bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]    ent_reg_r  [DEPTH];
    logic [DW-1:0]    ent_data_r [DEPTH];
    logic [DEPTH-1:0] vld_r;
    logic [DEPTH-1:0] kill_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;

    logic             regwrite_r;
    logic [AW-1:0]    wrreg_r;
    logic [DW-1:0]    wrdata_r;

    logic             alu_nz_s;
    logic             full_s;
    logic             push_s;
    logic             pop_s;
    logic             head_live_s;
    logic [2**AW-1:0] busy_s;

    assign alu_nz_s    = bus.alu_valid && (bus.alu_reg != {AW{1'b0}});
    assign full_s      = (count_r == FULL_CNT);
    assign push_s      = bus.mem_valid && !full_s;
    assign pop_s       = !bus.alu_valid && (count_r != {CW{1'b0}});
    assign head_live_s = !kill_r[rd_ptr_r] && (ent_reg_r[rd_ptr_r] != {AW{1'b0}});

    // Pending-write mask: every queued, unkilled entry targeting a real register
    always_comb begin
        busy_s = {(2**AW){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_r[i] && !kill_r[i] && (ent_reg_r[i] != {AW{1'b0}})) begin
                busy_s[ent_reg_r[i]] = 1'b1;
            end else begin
                busy_s = busy_s;
            end
        end
    end

    // FIFO storage, per-slot valid/kill state and WAW kill on ALU writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg_r[i]  <= {AW{1'b0}};
                ent_data_r[i] <= {DW{1'b0}};
            end
            vld_r    <= {DEPTH{1'b0}};
            kill_r   <= {DEPTH{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push_s && (PW'(i) == wr_ptr_r)) begin
                    // A same-edge push is older than the ALU write, so it is killed too
                    ent_reg_r[i]  <= bus.mem_reg;
                    ent_data_r[i] <= bus.mem_data;
                    vld_r[i]      <= 1'b1;
                    kill_r[i]     <= alu_nz_s && (bus.mem_reg == bus.alu_reg);
                end else if (pop_s && (PW'(i) == rd_ptr_r)) begin
                    vld_r[i]  <= 1'b0;
                    kill_r[i] <= 1'b0;
                end else if (vld_r[i] && alu_nz_s && (ent_reg_r[i] == bus.alu_reg)) begin
                    kill_r[i] <= 1'b1;
                end else begin
                    kill_r[i] <= kill_r[i];
                end
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Write-port register; wrreg/wrdata only move on a write that really happens
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite_r <= 1'b0;
            wrreg_r    <= {AW{1'b0}};
            wrdata_r   <= {DW{1'b0}};
        end else if (bus.alu_valid) begin
            regwrite_r <= alu_nz_s;
            if (alu_nz_s) begin
                wrreg_r  <= bus.alu_reg;
                wrdata_r <= bus.alu_data;
            end else begin
                wrreg_r  <= wrreg_r;
                wrdata_r <= wrdata_r;
            end
        end else if (pop_s) begin
            regwrite_r <= head_live_s;
            if (head_live_s) begin
                wrreg_r  <= ent_reg_r[rd_ptr_r];
                wrdata_r <= ent_data_r[rd_ptr_r];
            end else begin
                wrreg_r  <= wrreg_r;
                wrdata_r <= wrdata_r;
            end
        end else begin
            regwrite_r <= 1'b0;
            wrreg_r    <= wrreg_r;
            wrdata_r   <= wrdata_r;
        end
    end

    assign bus.mem_ready  = !full_s;
    assign bus.regwrite   = regwrite_r;
    assign bus.wrreg      = wrreg_r;
    assign bus.wrdata     = wrdata_r;
    assign bus.busy_mask  = busy_s;
    assign bus.fifo_count = count_r;
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios then random traffic, all compared
// against a queue-based reference model of the write-back rules.
module tb_wb_arbiter;
    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 5;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    wb_arbiter_if #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) bus ();
    wb_arbiter #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
        bit            k;
    } ent_t;

    ent_t          q[$];
    logic          m_rw;
    logic [AW-1:0] m_reg;
    logic [DW-1:0] m_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2**AW-1:0] model_busy();
        logic [2**AW-1:0] m;
        m = '0;
        foreach (q[i]) if (!q[i].k && q[i].r != 0) m[q[i].r] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        q.delete();
        m_rw   = 1'b0;
        m_reg  = '0;
        m_data = '0;
    endtask

    // One clock: drive inputs, compare everything at the falling edge, advance the model.
    task automatic cyc(input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                       input logic mv, input logic [AW-1:0] mr, input logic [DW-1:0] md,
                       output logic acc);
        ent_t e;
        bus.alu_valid = av; bus.alu_reg = ar; bus.alu_data = ad;
        bus.mem_valid = mv; bus.mem_reg = mr; bus.mem_data = md;
        @(negedge clk);
        chk("mem_ready",  {63'd0, bus.mem_ready}, {63'd0, (q.size() < DEPTH)});
        chk("fifo_count", 64'(bus.fifo_count), 64'(q.size()));
        chk("busy_mask",  64'(bus.busy_mask), 64'(model_busy()));
        chk("regwrite",   {63'd0, bus.regwrite}, {63'd0, m_rw});
        chk("wrreg",      64'(bus.wrreg), 64'(m_reg));
        chk("wrdata",     64'(bus.wrdata), 64'(m_data));
        acc = mv && (q.size() < DEPTH);
        if (av) begin
            m_rw = (ar != 0);
            if (ar != 0) begin
                m_reg = ar; m_data = ad;
                foreach (q[i]) if (q[i].r == ar) q[i].k = 1'b1;
            end
        end else if (q.size() > 0) begin
            e = q.pop_front();
            m_rw = !e.k && (e.r != 0);
            if (m_rw) begin
                m_reg = e.r; m_data = e.d;
            end
        end else begin
            m_rw = 1'b0;
        end
        if (acc) begin
            e.r = mr; e.d = md; e.k = av && (ar != 0) && (mr == ar);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, '0, '0, a);
    endtask

    initial begin
        logic          acc;
        int            k;
        logic [DW-1:0] mdata [5];
        checks = 0;
        errors = 0;
        model_reset();
        bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_reg = '0; bus.mem_data = '0;
        rst = 1'b1;
        #12;
        chk("rst_regwrite",  {63'd0, bus.regwrite}, 64'd0);
        chk("rst_wrreg",     64'(bus.wrreg), 64'd0);
        chk("rst_wrdata",    64'(bus.wrdata), 64'd0);
        chk("rst_count",     64'(bus.fifo_count), 64'd0);
        chk("rst_busy",      64'(bus.busy_mask), 64'd0);
        chk("rst_ready",     {63'd0, bus.mem_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: single ALU write, one-cycle latency
        cyc(1'b1, 5'd8, 32'h0000_1234, 1'b0, '0, '0, acc);
        chk("t1_regwrite", {63'd0, bus.regwrite}, 64'd1);
        chk("t1_wrreg",    64'(bus.wrreg), 64'd8);
        chk("t1_wrdata",   64'(bus.wrdata), 64'h1234);
        idle(1);

        // 2: memory write, two-cycle latency, busy bit while queued
        cyc(1'b0, '0, '0, 1'b1, 5'd9, 32'hAAAA_0001, acc);
        chk("t2_busy9",    64'(bus.busy_mask[9]), 64'd1);
        chk("t2_regwrite_early", {63'd0, bus.regwrite}, 64'd0);
        cyc(1'b0, '0, '0, 1'b0, '0, '0, acc);
        chk("t2_regwrite", {63'd0, bus.regwrite}, 64'd1);
        chk("t2_wrreg",    64'(bus.wrreg), 64'd9);
        chk("t2_busy",     64'(bus.busy_mask), 64'd0);
        idle(1);

        // 3: ALU streaming blocks the FIFO; it fills and backpressures
        for (int i = 0; i < 5; i++) mdata[i] = $urandom;
        k = 0;
        for (int i = 1; i <= 6; i++) begin
            cyc(1'b1, 5'(i), 32'(i * 16), (k < 5), 5'(20 + k), mdata[k % 5], acc);
            if (acc) k++;
            if (k == 4) begin
                chk("t3_ready_full", {63'd0, bus.mem_ready}, 64'd0);
                chk("t3_count_full", 64'(bus.fifo_count), 64'd4);
            end
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, '0, '0, (k < 5), 5'(20 + k), mdata[k % 5], acc);
            if (acc) k++;
        end
        chk("t3_all_pushed", 64'(k), 64'd5);

        // 4: WAW kill of a queued memory write
        cyc(1'b0, '0, '0, 1'b1, 5'd10, 32'h1, acc);
        cyc(1'b1, 5'd10, 32'h2, 1'b0, '0, '0, acc);
        chk("t4_busy10",   64'(bus.busy_mask[10]), 64'd0);
        chk("t4_wrdata",   64'(bus.wrdata), 64'h2);
        cyc(1'b0, '0, '0, 1'b0, '0, '0, acc);
        chk("t4_killed_rw", {63'd0, bus.regwrite}, 64'd0);
        chk("t4_wrdata_hold", 64'(bus.wrdata), 64'h2);
        // same-edge push and ALU write to one register: pushed entry is the older one
        cyc(1'b1, 5'd11, 32'h33, 1'b1, 5'd11, 32'h44, acc);
        chk("t4_sameedge_busy", 64'(bus.busy_mask[11]), 64'd0);
        idle(2);

        // 5: register zero from both producers
        cyc(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF, acc);
        chk("t5_rw_alu0",  {63'd0, bus.regwrite}, 64'd0);
        chk("t5_busy0",    64'(bus.busy_mask[0]), 64'd0);
        cyc(1'b0, '0, '0, 1'b0, '0, '0, acc);
        chk("t5_rw_mem0",  {63'd0, bus.regwrite}, 64'd0);
        idle(1);

        // 6: reset with three queued entries
        for (int i = 0; i < 3; i++) cyc(1'b1, 5'(1 + i), 32'(i), 1'b1, 5'(12 + i), 32'(100 + i), acc);
        chk("t6_count3", 64'(bus.fifo_count), 64'd3);
        bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_rw",    {63'd0, bus.regwrite}, 64'd0);
        chk("t6_rst_count", 64'(bus.fifo_count), 64'd0);
        chk("t6_rst_busy",  64'(bus.busy_mask), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        idle(4);

        // Random traffic with a small register pool so kills and reg-0 cases are frequent
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom,
                ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom, acc);
        end
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
